lc3_ctrl_fsm: RTL

Moore-style control sequencer for the reduced LC-3 datapath. It owns the select and load strobes (DRMUX, SR1MUX, LD_REG) that the 8x16 register file consumes, plus the PC, IR, MAR, MDR, bus-gate and SRAM controls. It steps fetch -> decode -> execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE. It sits between the top level (Run and Continue switches) and the datapath.

---
 rtl/lc3_ctrl_fsm.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lc3_ctrl_fsm.sv
// Moore control sequencer for the reduced LC-3 datapath: fetch, decode, execute.
// Latency: outputs are registered with the state and change on the edge that enters a state.
// Backpressure: none; HALTED waits for Run, PAUSE waits on a press/release Continue handshake.
module lc3_ctrl_fsm (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_OE_N,
  output logic        Mem_WE_N,
  output logic [4:0]  State_dbg
);

  // State codes double as the hex-display value. Classic LC-3 state numbers are
  // kept where they fit in 5 bits; the rest take free codes.
  typedef enum logic [4:0] {
    S00    = 5'd0,
    S01    = 5'd1,
    S33_1  = 5'd3,
    S04    = 5'd4,
    S05    = 5'd5,
    S06    = 5'd6,
    S07    = 5'd7,
    S09    = 5'd9,
    S33_2  = 5'd11,
    S12    = 5'd12,
    PAUSE1 = 5'd13,
    PAUSE2 = 5'd14,
    S16_1  = 5'd16,
    S16_2  = 5'd17,
    S18    = 5'd18,
    S35    = 5'd19,
    S32    = 5'd20,
    S21    = 5'd21,
    S22    = 5'd22,
    S23    = 5'd23,
    S25_1  = 5'd25,
    S25_2  = 5'd26,
    S27    = 5'd27,
    HALTED = 5'd31
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_oe_n;
    logic       mem_we_n;
  } ctrl_t;

  function automatic state_t next_of(state_t s, logic run, logic cont,
                                     logic [3:0] op, logic ben);
    state_t n;
    n = HALTED;
    case (s)
      HALTED: n = run ? S18 : HALTED;
      S18:    n = S33_1;
      S33_1:  n = S33_2;
      S33_2:  n = S35;
      S35:    n = S32;
      S32: begin
        case (op)
          4'b0001: n = S01;
          4'b0101: n = S05;
          4'b1001: n = S09;
          4'b0000: n = S00;
          4'b1100: n = S12;
          4'b0100: n = S04;
          4'b0110: n = S06;
          4'b0111: n = S07;
          4'b1101: n = PAUSE1;
          default: n = S18;
        endcase
      end
      S01, S05, S09, S12, S22, S21, S27, S16_2: n = S18;
      S00:    n = ben ? S22 : S18;
      S04:    n = S21;
      S06:    n = S25_1;
      S25_1:  n = S25_2;
      S25_2:  n = S27;
      S07:    n = S23;
      S23:    n = S16_1;
      S16_1:  n = S16_2;
      PAUSE1: n = cont ? PAUSE2 : PAUSE1;
      PAUSE2: n = cont ? PAUSE2 : S18;
      default: n = HALTED;
    endcase
    return n;
  endfunction

  function automatic ctrl_t ctrl_of(state_t s, logic ir5);
    ctrl_t c;
    c = '0;
    c.mem_oe_n = 1'b1;
    c.mem_we_n = 1'b1;
    case (s)
      S18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
      end
      S33_1, S25_1: c.mem_oe_n = 1'b0;
      S33_2, S25_2: begin
        c.mem_oe_n = 1'b0;
        c.ld_mdr   = 1'b1;
      end
      S35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      S32: c.ld_ben = 1'b1;
      S01, S05: begin
        c.sr2mux   = ir5;
        c.aluk     = (s == S05) ? 2'b01 : 2'b00;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S09: begin
        c.aluk     = 2'b10;
        c.gate_alu = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S22: begin
        c.addr2mux = 2'b10;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S12: begin
        c.aluk     = 2'b11;
        c.gate_alu = 1'b1;
        c.pcmux    = 2'b01;
        c.ld_pc    = 1'b1;
      end
      S04: begin
        c.gate_pc = 1'b1;
        c.drmux   = 1'b1;
        c.ld_reg  = 1'b1;
      end
      S21: begin
        c.addr2mux = 2'b11;
        c.pcmux    = 2'b10;
        c.ld_pc    = 1'b1;
      end
      S06, S07: begin
        c.addr1mux    = 1'b1;
        c.addr2mux    = 2'b01;
        c.gate_marmux = 1'b1;
        c.ld_mar      = 1'b1;
      end
      S27: begin
        c.gate_mdr = 1'b1;
        c.ld_reg   = 1'b1;
        c.ld_cc    = 1'b1;
      end
      S23: begin
        c.sr1mux   = 1'b1;
        c.aluk     = 2'b11;
        c.gate_alu = 1'b1;
        c.ld_mdr   = 1'b1;
      end
      S16_1, S16_2: c.mem_we_n = 1'b0;
      default: ;
    endcase
    return c;
  endfunction

  state_t state;
  state_t nxt;
  ctrl_t  ctrl_q;
  logic   ld_led_q;
  logic   ir_unused;

  // Only the opcode and the immediate-select bit steer the sequencer.
  assign ir_unused = ^{IR[11:6], IR[4:0]};

  assign nxt = next_of(state, Run, Continue, IR[15:12], BEN);

  // Step the state and register the outputs of the state being entered, so no
  // strobe is ever a decode of a changing state vector (no glitches on Mem_WE_N).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= HALTED;
      ctrl_q   <= ctrl_of(HALTED, 1'b0);
      ld_led_q <= 1'b0;
    end else begin
      state    <= nxt;
      ctrl_q   <= ctrl_of(nxt, IR[5]);
      ld_led_q <= (nxt == PAUSE1) && (state != PAUSE1);
    end
  end

  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign LD_BEN     = ctrl_q.ld_ben;
  assign LD_CC      = ctrl_q.ld_cc;
  assign LD_REG     = ctrl_q.ld_reg;
  assign LD_PC      = ctrl_q.ld_pc;
  assign LD_LED     = ld_led_q;
  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateALU    = ctrl_q.gate_alu;
  assign GateMARMUX = ctrl_q.gate_marmux;
  assign PCMUX      = ctrl_q.pcmux;
  assign DRMUX      = ctrl_q.drmux;
  assign SR1MUX     = ctrl_q.sr1mux;
  assign SR2MUX     = ctrl_q.sr2mux;
  assign ADDR1MUX   = ctrl_q.addr1mux;
  assign ADDR2MUX   = ctrl_q.addr2mux;
  assign ALUK       = ctrl_q.aluk;
  assign Mem_OE_N   = ctrl_q.mem_oe_n;
  assign Mem_WE_N   = ctrl_q.mem_we_n;
  assign State_dbg  = state;

endmodule
